leaf_user_fifo: RTL and testbench
=================================

# leaf_user_fifo

Elastic FIFO that sits between a leaf_interface user-side port and an HLS kernel stream port (e.g. interface→kernel input, kernel→interface output). Decouples the kernel's TVALID/TREADY timing from the interface's vld/ack timing and absorbs bursts. First-word-fall-through output with registered handshake signals, so no combinational path runs from the downstream ack to the upstream ack.

## Interface
Parameters:
- PAYLOAD_BITS, 32, data width; matches the leaf_interface payload.
- DEPTH_BITS, 4, log2 of storage depth (DEPTH = 2**DEPTH_BITS = 16 entries).
- ALMOST_FULL_THRESH, 12, occupancy at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  **synchronous, active-high** reset.
- din  in  PAYLOAD_BITS  upstream data.
- vld_in  in  1  upstream valid.
- ack_out  out  1  upstream ready; equals !full.
- dout  out  PAYLOAD_BITS  head-of-FIFO data.
- vld_out  out  1  head entry valid; equals !empty.
- ack_in  in  1  downstream ready.
- count  out  DEPTH_BITS+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= ALMOST_FULL_THRESH.

## Operation
- Push when vld_in && ack_out in the same cycle; pop when vld_out && ack_in in the same cycle.
- Storage is a DEPTH-entry circular buffer. Write pointer wr_ptr and read pointer rd_ptr are DEPTH_BITS wide and wrap modulo DEPTH. Occupancy is tracked by a separate count register.
- count update per cycle: push only +1; pop only −1; both or neither unchanged.
- full = (count == DEPTH); empty = (count == 0). Both are derived from the registered count.
- Full: ack_out is low, so no push happens even if a pop happens in the same cycle. ack_out rises the cycle after the pop.
- Empty: vld_out is low. A push into an empty FIFO makes the data visible on dout with vld_out high the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop at 0 < count < DEPTH: both pointers advance and count is held. Steady-state throughput is 1 beat/cycle.
- dout always reflects mem[rd_ptr]. Its value is don't-care while vld_out is low.
- Once vld_out is asserted, dout must hold stable until the pop.
- Reset mid-operation drops all contents. No partial beat is emitted after reset.

## Timing
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, ack_out = 1, vld_out = 0, almost_full = 0. dout is undefined (storage is not cleared).
- Latency: a push at cycle N is visible at cycle N+1.
- ack_out, vld_out and almost_full are functions of registered state only. There is no combinational path from any input to any output.
- During the reset cycle, inputs are ignored. The first push can be accepted in the cycle after reset deasserts.

## Configuration
- LEAF_USER_FIFO_STATS_EN defined: adds two output ports.
  - beat_count, 32 bits: total pops since reset; wraps modulo 2^32.
  - stall_count, 32 bits: cycles with vld_in && !ack_out; saturates at 0xFFFF_FFFF.
  - Both reset to 0.
- Not defined: the ports and counters are absent, and FIFO behaviour is identical.

## Structure
- Shared package leaf_stream_pkg:
  - PAYLOAD_BITS default constant.
  - A payload_t typedef.
  - A count-width helper function (DEPTH_BITS+1).
- Sub-module leaf_fifo_ram: simple dual-port storage with one write port and one asynchronous read port at rd_ptr. The top level owns the pointers, count, flags and optional counters.

## Test plan
- Reset, then push 16 beats 0x00..0x0F with ack_in = 0:
  - ack_out falls after the 16th accept.
  - count = 16.
  - almost_full rises when count reaches 12.
  - vld_out rises one cycle after the first push.
- Full FIFO with vld_in = 1, then ack_in = 1 for one cycle:
  - pop of 0x00.
  - no push that cycle.
  - ack_out = 1 the next cycle.
  - count goes 16 → 15 → 16.
- Continuous vld_in and ack_in held at 1 for 100 beats of an incrementing pattern:
  - dout order matches the input order.
  - after the first beat, throughput is 1 beat/cycle.
  - count stays at 1.
- Random vld_in and ack_in (50% each), 10,000 beats: a scoreboard sees no loss, duplication or reordering across pointer wrap.
- Assert reset with count = 7:
  - next cycle count = 0, vld_out = 0, ack_out = 1.
  - a subsequent push of 0xA5 appears alone on dout.
- With LEAF_USER_FIFO_STATS_EN defined, 20 pops and 5 stall cycles give beat_count = 20 and stall_count = 5.

Source files
------------

// File: rtl/leaf_stream_pkg.sv
// Shared types and helpers for the leaf_interface stream blocks.
// Used by leaf_user_fifo and its storage sub-module.
package leaf_stream_pkg;

  localparam int LEAF_PAYLOAD_BITS = 32;

  typedef logic [LEAF_PAYLOAD_BITS-1:0] payload_t;

  // An occupancy counter must represent 0..2**depth_bits inclusive.
  function automatic int count_width(input int depth_bits);
    return depth_bits + 1;
  endfunction

endpackage

// File: rtl/leaf_fifo_ram.sv
// Simple dual-port storage for leaf_user_fifo: one synchronous write port
// and one asynchronous read port. Contents are never cleared.
module leaf_fifo_ram
  import leaf_stream_pkg::*;
#(
  parameter int WIDTH     = LEAF_PAYLOAD_BITS,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  localparam int ENTRIES = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem [0:ENTRIES-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read address comes straight from a register, so dout has no input path.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/leaf_user_fifo.sv
// First-word-fall-through elastic FIFO between a leaf_interface user port and
// an HLS stream port. Define LEAF_USER_FIFO_STATS_EN to add beat/stall counters.
module leaf_user_fifo
  import leaf_stream_pkg::*;
#(
  parameter int PAYLOAD_BITS       = LEAF_PAYLOAD_BITS,
  parameter int DEPTH_BITS         = 4,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [PAYLOAD_BITS-1:0]             din,
  input  logic                                vld_in,
  output logic                                ack_out,
  output logic [PAYLOAD_BITS-1:0]             dout,
  output logic                                vld_out,
  input  logic                                ack_in,
  output logic [count_width(DEPTH_BITS)-1:0]  count,
  output logic                                almost_full
`ifdef LEAF_USER_FIFO_STATS_EN
  ,
  output logic [31:0]                         beat_count,
  output logic [31:0]                         stall_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = count_width(DEPTH_BITS);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THRESH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_next;
  logic                  push;
  logic                  pop;

  assign push  = vld_in && ack_out;
  assign pop   = vld_out && ack_in;
  assign count = count_q;

  always_comb begin
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + ONE_C;
    end else if (pop && !push) begin
      count_next = count_q - ONE_C;
    end
  end

  // Flags are registered from the next occupancy so they track count exactly
  // while keeping ack_in off any combinational path to ack_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      ack_out     <= 1'b1;
      vld_out     <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      end
      count_q     <= count_next;
      ack_out     <= (count_next != DEPTH_C);
      vld_out     <= (count_next != '0);
      almost_full <= (count_next >= AF_C);
    end
  end

  leaf_fifo_ram #(
    .WIDTH     (PAYLOAD_BITS),
    .ADDR_BITS (DEPTH_BITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push && !reset),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_addr (rd_ptr),
    .rd_data (dout)
  );

`ifdef LEAF_USER_FIFO_STATS_EN
  // beat_count wraps naturally; stall_count pins at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_count  <= '0;
      stall_count <= '0;
    end else begin
      if (pop) begin
        beat_count <= beat_count + 32'd1;
      end
      if (vld_in && !ack_out && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_leaf_user_fifo.sv
// Self-checking bench for leaf_user_fifo: a table of fill vectors plus
// hand-written corner sequences, all backed by a queue-based scoreboard.
module tb_leaf_user_fifo;
  import leaf_stream_pkg::*;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk = 1'b0;
  logic       reset;
  payload_t   din;
  logic       vld_in;
  logic       ack_out;
  payload_t   dout;
  logic       vld_out;
  logic       ack_in;
  logic [4:0] count;
  logic       almost_full;
`ifdef LEAF_USER_FIFO_STATS_EN
  logic [31:0] beat_count;
  logic [31:0] stall_count;
`endif

  int n_vectors     = 0;
  int n_miscompares = 0;

  payload_t m_q[$];
  int       m_beats;
  int       m_stalls;

  typedef struct {
    logic       v;
    payload_t   d;
    logic       a;
    logic       e_ack;
    logic       e_vld;
    logic [4:0] e_cnt;
    logic       e_af;
    logic       chk_dout;
    payload_t   e_dout;
  } vec_t;

  vec_t vecs [17];

  always #5 clk = ~clk;

  leaf_user_fifo #(
    .PAYLOAD_BITS       (32),
    .DEPTH_BITS         (4),
    .ALMOST_FULL_THRESH (AF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .vld_in      (vld_in),
    .ack_out     (ack_out),
    .dout        (dout),
    .vld_out     (vld_out),
    .ack_in      (ack_in),
    .count       (count),
    .almost_full (almost_full)
`ifdef LEAF_USER_FIFO_STATS_EN
    ,
    .beat_count  (beat_count),
    .stall_count (stall_count)
`endif
  );

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the scoreboard's view of occupancy and head.
  task automatic checkOutput();
    compare("ack_out",     32'(ack_out),     32'(m_q.size() != DEPTH));
    compare("vld_out",     32'(vld_out),     32'(m_q.size() != 0));
    compare("count",       32'(count),       32'(m_q.size()));
    compare("almost_full", 32'(almost_full), 32'(m_q.size() >= AF));
    if (m_q.size() != 0) begin
      compare("dout", dout, m_q[0]);
    end
  endtask

  // Advance the model by one handshake cycle, then step to just after the edge.
  task automatic modelStep(input logic v, input payload_t d, input logic a);
    logic do_push;
    logic do_pop;
    do_push = v && (m_q.size() != DEPTH);
    do_pop  = a && (m_q.size() != 0);
    if (v && !do_push) m_stalls++;
    if (do_pop) begin
      void'(m_q.pop_front());
      m_beats++;
    end
    if (do_push) m_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input payload_t d, input logic a);
    vld_in = v;
    din    = d;
    ack_in = a;
    checkOutput();
    modelStep(v, d, a);
  endtask

  task automatic doReset();
    reset  = 1'b1;
    vld_in = 1'b0;
    ack_in = 1'b0;
    din    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_q.delete();
    m_beats  = 0;
    m_stalls = 0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pushed;
    int cyc;
    logic v;
    logic a;

    doReset();
    compare("rst_count",   32'(count),       32'd0);
    compare("rst_ack_out", 32'(ack_out),     32'd1);
    compare("rst_vld_out", 32'(vld_out),     32'd0);
    compare("rst_af",      32'(almost_full), 32'd0);

    // Fill to full with the sink stalled; the last vector pushes against full.
    for (int i = 0; i < 17; i++) begin
      vecs[i].v        = 1'b1;
      vecs[i].d        = 32'(i);
      vecs[i].a        = 1'b0;
      vecs[i].e_ack    = (i < DEPTH);
      vecs[i].e_vld    = (i > 0);
      vecs[i].e_cnt    = 5'(i);
      vecs[i].e_af     = (i >= AF);
      vecs[i].chk_dout = (i > 0);
      vecs[i].e_dout   = 32'h0;
    end
    for (int i = 0; i < 17; i++) begin
      vld_in = vecs[i].v;
      din    = vecs[i].d;
      ack_in = vecs[i].a;
      compare("vec_ack_out", 32'(ack_out),     32'(vecs[i].e_ack));
      compare("vec_vld_out", 32'(vld_out),     32'(vecs[i].e_vld));
      compare("vec_count",   32'(count),       32'(vecs[i].e_cnt));
      compare("vec_af",      32'(almost_full), 32'(vecs[i].e_af));
      if (vecs[i].chk_dout) compare("vec_dout", dout, vecs[i].e_dout);
      modelStep(vecs[i].v, vecs[i].d, vecs[i].a);
    end

    // Pop while full and still offering data: no push may sneak in.
    compare("full_head", dout, 32'h0);
    applyStimulus(1'b1, 32'h10, 1'b1);
    compare("after_pop_count", 32'(count),   32'd15);
    compare("after_pop_ack",   32'(ack_out), 32'd1);
    compare("after_pop_head",  dout,         32'h1);
    applyStimulus(1'b1, 32'h10, 1'b0);
    compare("refill_count", 32'(count),   32'd16);
    compare("refill_ack",   32'(ack_out), 32'd0);
    for (int i = 0; i < 40 && m_q.size() != 0; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    compare("drain_vld", 32'(vld_out), 32'd0);

    // Streaming at one beat per cycle should hold occupancy at one.
    for (int i = 0; i < 100; i++) begin
      if (i > 0) begin
        compare("stream_count", 32'(count),   32'd1);
        compare("stream_vld",   32'(vld_out), 32'd1);
        compare("stream_dout",  dout,         32'h100 + 32'(i - 1));
      end
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    compare("stream_end_count", 32'(count), 32'd0);

    // Random traffic across many pointer wraps.
    pushed = 0;
    cyc    = 0;
    while ((pushed < 10000 || m_q.size() != 0) && cyc < 60000) begin
      v = (pushed < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      a = 1'($urandom_range(0, 1));
      if (v && m_q.size() != DEPTH) pushed++;
      applyStimulus(v, 32'($urandom), a);
      cyc++;
    end
    compare("random_complete", 32'(pushed == 10000 && m_q.size() == 0), 32'd1);

    // Reset with seven entries held; inputs during reset must be ignored.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0);
    compare("pre_reset_count", 32'(count), 32'd7);
    reset  = 1'b1;
    vld_in = 1'b1;
    din    = 32'hDEAD_BEEF;
    ack_in = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_q.delete();
    compare("mid_rst_count", 32'(count),       32'd0);
    compare("mid_rst_vld",   32'(vld_out),     32'd0);
    compare("mid_rst_ack",   32'(ack_out),     32'd1);
    compare("mid_rst_af",    32'(almost_full), 32'd0);
    applyStimulus(1'b1, 32'hA5, 1'b0);
    compare("post_rst_vld",   32'(vld_out), 32'd1);
    compare("post_rst_dout",  dout,         32'hA5);
    compare("post_rst_count", 32'(count),   32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    compare("post_rst_alone_vld",   32'(vld_out), 32'd0);
    compare("post_rst_alone_count", 32'(count),   32'd0);

`ifdef LEAF_USER_FIFO_STATS_EN
    doReset();
    compare("stats_rst_beats",  beat_count,  32'd0);
    compare("stats_rst_stalls", stall_count, 32'd0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0);
    for (int i = 0; i < 5; i++)  applyStimulus(1'b1, 32'h55, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++)  applyStimulus(1'b1, 32'h60 + 32'(i), 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    compare("beat_count",        beat_count,  32'd20);
    compare("stall_count",       stall_count, 32'd5);
    compare("beat_count_model",  beat_count,  32'(m_beats));
    compare("stall_count_model", stall_count, 32'(m_stalls));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
